hilo_div_ctrl: RTL

- Sequencing controller between the MIPS decode/execute stage and stream_divider, which runs 32 bit-serial iterations and is signed-only.
- Accepts DIV, MTHI, MTLO and MFHI/MFLO requests.
- Holds the operands stable for the whole divide, drives the divider's level-sensitive start, and captures quotient to LO and remainder to HI.
- Owns the HI/LO registers and the stall/interlock for dependent reads.

---
 rtl/hilo_pkg.sv | 22 ++
 rtl/hilo_div_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO divide sequencing controller.
//   op_e        : request opcode encoding on req_op
//   state_e     : controller state encoding
//   DIV_LATENCY : cycles from the first start edge to the divider's done pulse
package hilo_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_MTHI = 2'b01,
    OP_MTLO = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    ABORT = 2'b10
  } state_e;

  localparam int unsigned DIV_LATENCY = 34;

endpackage

// File: rtl/hilo_div_ctrl.sv
// HI/LO register owner and sequencer for an external bit-serial signed divider.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   req_valid/ready/op  : request handshake; op selects DIV / MTHI / MTLO / NOP
//   req_a, req_b        : dividend (or MTHI/MTLO data), divisor
//   flush               : cancel a divide in flight
//   rd_sel, rd_data     : HI(1)/LO(0) read port, rd_stall while a divide is pending
//   busy, err_timeout   : divide in flight, sticky divider-timeout flag
//   div_*               : divider interface (reset, start, held operands, done, results)
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DIV_TIMEOUT = 40,
  parameter int unsigned CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_stall,
  output logic             busy,
  output logic             err_timeout,
  output logic             div_reset,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_reminder
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q, start_d;
  logic               err_q, err_d;

  logic accept;
  logic div_by_zero;
  logic timeout_hit;

  assign accept      = req_valid && (state_q == IDLE);
  assign div_by_zero = (req_b == '0);
  // Counter holds the number of completed RUN cycles; fires on the last allowed one.
  assign timeout_hit = (cnt_q == CNT_W'(DIV_TIMEOUT - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; flush outranks done, done outranks timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && (req_op == OP_DIV) && !div_by_zero) state_d = RUN;
      end
      RUN: begin
        if (flush)            state_d = ABORT;
        else if (div_done)    state_d = IDLE;
        else if (timeout_hit) state_d = ABORT;
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register updates: HI/LO writes, operand latch, start level, RUN counter
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (req_op)
            OP_DIV: begin
              if (div_by_zero) begin
                // MIPS-style divide-by-zero result without touching the divider
                hi_d = req_a;
                lo_d = '1;
              end else begin
                dvd_d   = req_a;
                dvs_d   = req_b;
                cnt_d   = '0;
                start_d = 1'b1;
              end
            end
            OP_MTHI: hi_d = req_a;
            OP_MTLO: lo_d = req_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush) begin
          start_d = 1'b0;
        end else if (div_done) begin
          lo_d    = div_quotient;
          hi_d    = div_reminder;
          start_d = 1'b0;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          start_d = 1'b0;
        end
      end
      // Start stays low for a full cycle so the divider clears its iteration count
      ABORT:   start_d = 1'b0;
      default: start_d = 1'b0;
    endcase
  end

  // Outputs decoded from registers
  always_comb begin
    req_ready    = (state_q == IDLE);
    busy         = (state_q == RUN) || (state_q == ABORT);
    rd_stall     = busy;
    rd_data      = rd_sel ? hi_q : lo_q;
    err_timeout  = err_q;
    div_reset    = ~reset;
    div_start    = start_q;
    div_dividend = dvd_q;
    div_divisor  = dvs_q;
  end

endmodule
